frame_stream_ctrl: RTL and testbench
====================================

// Module: frame_stream_ctrl
// PURPOSE
//  Frame sequencer between source image RAM, pixel-processing core (gorev-style: en/veri_al/veri_gonder/islem_bitti)
//  and result RAM. On start it streams N_PIX pixels from source RAM into the core under a valid/ready handshake,
//  concurrently writes every core result to destination RAM at consecutive addresses, then pulses done.
//  Replaces fixed wait-count sequencing in the gorev top levels with handshake-exact control.
// PARAMETERS
//  PIX_W   8      pixel width (bits)
//  N_PIX   76800  pixels per frame (320x240)
//  ADDR_W  17     RAM address width; 2**ADDR_W >= N_PIX
// PORTS
//  clk_i        in   1       clock, all logic on rising edge
//  rst_i        in   1       asynchronous, active-high reset
//  start_i      in   1       frame start request (sampled in IDLE only)
//  abort_i      in   1       synchronous abort, returns to IDLE
//  busy_o       out  1       high from accepted start until done pulse/abort
//  done_o       out  1       one-cycle pulse, frame complete
//  err_o        out  1       sticky protocol error, cleared by next accepted start
//  src_en_o     out  1       source RAM read enable
//  src_addr_o   out  ADDR_W  source RAM read address
//  src_data_i   in   PIX_W   source RAM data, valid 1 cycle after src_en_o
//  core_en_o    out  1       core enable
//  core_valid_o out  1       core_data_o holds a pixel
//  core_data_o  out  PIX_W   pixel to core
//  core_ready_i in   1       core accepts pixel (veri_al)
//  core_valid_i in   1       core result valid (veri_gonder)
//  core_data_i  in   PIX_W   core result
//  core_done_i  in   1       core finished frame (islem_bitti)
//  dst_en_o     out  1       destination RAM enable
//  dst_we_o     out  1       destination RAM write enable
//  dst_addr_o   out  ADDR_W  destination write address
//  dst_data_o   out  PIX_W   destination write data
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, state IDLE; reset mid-frame drops core_en_o immediately, no partial done.
//  States: IDLE -(start_i)-> FEED -(rd_cnt==N_PIX && buffer empty)-> DRAIN -(wr_cnt==N_PIX)-> DONE -> IDLE.
//  abort_i in FEED/DRAIN/DONE -> IDLE next cycle, no done_o; abort_i beats start_i in same cycle.
//  start_i while busy ignored. Accepted start clears rd_cnt, wr_cnt, err_o; busy_o=1 and core_en_o=1 next cycle.
//  Feed: 2-entry pixel FIFO. Read issued (src_en_o=1, src_addr_o=rd_cnt, rd_cnt++) when
//    rd_cnt<N_PIX and (FIFO occupancy + reads in flight) < 2. Returned data enters FIFO 1 cycle later.
//  core_valid_o = FIFO non-empty; core_data_o = FIFO head; pop when core_valid_o && core_ready_i.
//    Data stable while core_valid_o && !core_ready_i. Sustained throughput 1 pixel/cycle when ready held high.
//  Collect (FEED and DRAIN): core_valid_i at cycle t -> cycle t+1: dst_en_o=dst_we_o=1,
//    dst_addr_o=wr_cnt, dst_data_o=core_data_i; wr_cnt++. dst_en_o/dst_we_o low otherwise.
//  Simultaneous pop and result in one cycle both handled; counters independent.
//  DONE: done_o=1 for exactly one cycle, busy_o=0 and core_en_o=0 in the same cycle.
//  Errors (err_o set, operation continues): core_valid_i when wr_cnt==N_PIX or in IDLE/DONE;
//    core_done_i high while wr_cnt<N_PIX in FEED/DRAIN.
//  Counters are ADDR_W+1 bits; last read/write address N_PIX-1, never wraps past N_PIX.
// TESTING
//  T1 N_PIX=8, core ready=1, echo results 3 cycles later -> dst writes addr 0..7 data=src, done_o one pulse, err_o=0.
//  T2 core_ready_i toggled random 50% -> core_data_o stable while stalled, pixels in order 0..7, no loss/dup.
//  T3 back-to-back reads, ready=1 -> src_addr_o increments every cycle after first, core_valid_o continuous.
//  T4 abort_i mid FEED at rd_cnt=4 -> IDLE next cycle, busy_o=0, no done_o; new start runs full clean frame.
//  T5 rst_i asserted asynchronously mid DRAIN -> all outputs 0 without clock edge; restart completes normally.
//  T6 core sends 9th result, or core_done_i at wr_cnt=5 -> err_o=1 sticky; cleared by next start.

Source files
------------

// File: rtl/frame_stream_ctrl.sv
// Frame sequencer: streams N_PIX source-RAM pixels into a pixel core through a
// 2-entry skid FIFO, writes every core result to destination RAM in order and
// pulses done once the last result has been written.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | waiting for start_i; FIFO flushed, core disabled
//   ST_FEED   | issuing source reads, feeding the core, collecting results
//   ST_DRAIN  | all pixels delivered; collecting the remaining results
//   ST_DONE   | single-cycle done pulse, busy and core enable already low
module frame_stream_ctrl #(
  parameter int PIX_W  = 8,
  parameter int N_PIX  = 76800,
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              src_en_o,
  output logic [ADDR_W-1:0] src_addr_o,
  input  logic [PIX_W-1:0]  src_data_i,
  output logic              core_en_o,
  output logic              core_valid_o,
  output logic [PIX_W-1:0]  core_data_o,
  input  logic              core_ready_i,
  input  logic              core_valid_i,
  input  logic [PIX_W-1:0]  core_data_i,
  input  logic              core_done_i,
  output logic              dst_en_o,
  output logic              dst_we_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [PIX_W-1:0]  dst_data_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_PIX_C = CNT_W'(N_PIX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [PIX_W-1:0]  fifo0_q, fifo0_d;
  logic [PIX_W-1:0]  fifo1_q, fifo1_d;
  logic              dst_vld_q, dst_vld_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [PIX_W-1:0]  dst_data_q, dst_data_d;
  logic              err_q, err_d;

  logic              active;
  logic              start_acc;
  logic              fifo_valid;
  logic              pop;
  logic              push;
  logic              flush;
  logic [2:0]        occ_next;
  logic              rd_issue;
  logic              collect;
  logic              err_evt;

  // Per-cycle decode of handshakes, read issue and result capture.
  always_comb begin
    active     = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    start_acc  = (state_q == ST_IDLE) && start_i && !abort_i;
    fifo_valid = (state_q == ST_FEED) && (fifo_cnt_q != 2'd0);
    pop        = fifo_valid && core_ready_i;
    // Returned data from last cycle's read is pushed this cycle.
    push       = (state_q == ST_FEED) && inflight_q;
    flush      = (state_q != ST_FEED) || abort_i;
    // Credit check counts this cycle's pop so a held-high ready sustains
    // one read per cycle without overrunning the two entries.
    occ_next   = {1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
    rd_issue   = (state_q == ST_FEED) && !abort_i &&
                 (rd_cnt_q < N_PIX_C) && (occ_next < 3'd2);
    collect    = active && !abort_i && core_valid_i && (wr_cnt_q < N_PIX_C);
    err_evt    = (core_valid_i && (!active || (wr_cnt_q == N_PIX_C))) ||
                 (core_done_i && active && (wr_cnt_q < N_PIX_C));
  end

  // Next-state logic; abort wins over everything including a same-cycle start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) state_d = ST_FEED;
      end
      ST_FEED: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if ((rd_cnt_q == N_PIX_C) && (fifo_cnt_q == 2'd0) && !inflight_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (wr_cnt_q == N_PIX_C) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read and write counters; cleared by an accepted start, never past N_PIX.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (start_acc) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (rd_issue) rd_cnt_d = rd_cnt_q + CNT_ONE;
      if (collect)  wr_cnt_d = wr_cnt_q + CNT_ONE;
    end
  end

  // Two-entry pixel FIFO; fifo0 is always the head presented to the core.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    inflight_d = rd_issue;
    if (flush) begin
      fifo_cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) fifo0_d = src_data_i;
          else                    fifo1_d = src_data_i;
          fifo_cnt_d = fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          fifo0_d    = fifo1_q;
          fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo0_d = src_data_i;
          end else begin
            fifo0_d = fifo1_q;
            fifo1_d = src_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result capture: a result seen this cycle becomes a RAM write next cycle.
  always_comb begin
    dst_vld_d  = collect;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    if (collect) begin
      dst_addr_d = wr_cnt_q[ADDR_W-1:0];
      dst_data_d = core_data_i;
    end
  end

  // Sticky protocol error; only an accepted start clears it.
  always_comb begin
    err_d = err_q;
    if (start_acc) begin
      err_d = 1'b0;
    end else if (err_evt) begin
      err_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      dst_vld_q  <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      dst_vld_q  <= dst_vld_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      err_q      <= err_d;
    end
  end

  // Outputs derive from registers so reset clears them without a clock edge.
  always_comb begin
    busy_o       = active;
    core_en_o    = active;
    done_o       = (state_q == ST_DONE);
    err_o        = err_q;
    src_en_o     = rd_issue;
    src_addr_o   = rd_cnt_q[ADDR_W-1:0];
    core_valid_o = fifo_valid;
    core_data_o  = fifo0_q;
    dst_en_o     = dst_vld_q;
    dst_we_o     = dst_vld_q;
    dst_addr_o   = dst_addr_q;
    dst_data_o   = dst_data_q;
  end

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Directed bench for frame_stream_ctrl with a small source RAM, an echoing core
// model and a scoreboard of expected destination writes.
module tb_frame_stream_ctrl;

  localparam int PIX_W  = 8;
  localparam int N_PIX  = 8;
  localparam int ADDR_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i, abort_i;
  logic              busy_o, done_o, err_o;
  logic              src_en_o;
  logic [ADDR_W-1:0] src_addr_o;
  logic [PIX_W-1:0]  src_data_i;
  logic              core_en_o, core_valid_o;
  logic [PIX_W-1:0]  core_data_o;
  logic              core_ready_i, core_valid_i, core_done_i;
  logic [PIX_W-1:0]  core_data_i;
  logic              dst_en_o, dst_we_o;
  logic [ADDR_W-1:0] dst_addr_o;
  logic [PIX_W-1:0]  dst_data_o;

  frame_stream_ctrl #(.PIX_W(PIX_W), .N_PIX(N_PIX), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .src_en_o(src_en_o), .src_addr_o(src_addr_o), .src_data_i(src_data_i),
    .core_en_o(core_en_o), .core_valid_o(core_valid_o), .core_data_o(core_data_o),
    .core_ready_i(core_ready_i), .core_valid_i(core_valid_i), .core_data_i(core_data_i),
    .core_done_i(core_done_i),
    .dst_en_o(dst_en_o), .dst_we_o(dst_we_o), .dst_addr_o(dst_addr_o), .dst_data_o(dst_data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [PIX_W-1:0]  src_mem [0:15];
  bit                rd_pend;
  logic [ADDR_W-1:0] rd_pend_addr;
  int rd_exp, pix_idx, n_res, done_cnt;
  int first_rd, last_rd, first_pop, last_pop;
  bit rdy_rand, extra_res, prev_stall, start_req, abort_req;
  int done_mode;
  logic [PIX_W-1:0] prev_data;

  int               due_q[$];
  logic [PIX_W-1:0] res_q[$];
  int               exp_due[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [PIX_W-1:0] exp_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {busy_o, done_o, err_o, src_en_o, core_en_o, core_valid_o, dst_en_o, dst_we_o,
            src_addr_o, core_data_o, dst_addr_o, dst_data_o};
  endfunction

  task automatic flush_model();
    rd_pend = 1'b0;
    prev_stall = 1'b0;
    due_q.delete();
    res_q.delete();
    exp_due.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic clr_model();
    flush_model();
    rd_exp = 0; pix_idx = 0; n_res = 0; done_cnt = 0;
    first_rd = 0; last_rd = 0; first_pop = 0; last_pop = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, then observe.
  task automatic cycle();
    @(negedge clk_i);
    cyc++;
    if (rd_pend) src_data_i = src_mem[rd_pend_addr];
    rd_pend = 1'b0;
    core_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    core_valid_i = 1'b0;
    core_data_i  = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      core_valid_i = 1'b1;
      core_data_i  = res_q[0];
      void'(due_q.pop_front());
      void'(res_q.pop_front());
      if (n_res < N_PIX) begin
        exp_due.push_back(cyc + 1);
        exp_addr.push_back(ADDR_W'(n_res));
        exp_data.push_back(core_data_i);
      end
      n_res++;
    end
    core_done_i = 1'b0;
    if (done_mode != 0 && exp_due.size() > 0 && exp_due[0] == cyc &&
        exp_addr[0] == ADDR_W'(done_mode == 1 ? 7 : 4))
      core_done_i = 1'b1;
    start_i = start_req;
    abort_i = abort_req;
    #1;
    if (src_en_o) begin
      chk("src_addr", 32'(src_addr_o), 32'(rd_exp));
      if (rd_exp == 0) first_rd = cyc;
      last_rd = cyc;
      rd_exp++;
      rd_pend = 1'b1;
      rd_pend_addr = src_addr_o;
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(core_valid_o), 32'd1);
      chk("stall_data", 32'(core_data_o), 32'(prev_data));
    end
    prev_stall = core_valid_o && !core_ready_i && !abort_i;
    prev_data  = core_data_o;
    if (core_valid_o && core_ready_i && !abort_i) begin
      if (pix_idx < N_PIX) begin
        chk("pix_order", 32'(core_data_o), 32'(src_mem[pix_idx]));
        due_q.push_back(cyc + 3);
        res_q.push_back(src_mem[pix_idx]);
        if (extra_res && pix_idx == N_PIX - 1) begin
          due_q.push_back(cyc + 4);
          res_q.push_back(8'hEE);
        end
      end else begin
        chk("pix_extra", 32'(pix_idx), 32'(N_PIX - 1));
      end
      if (pix_idx == 0) first_pop = cyc;
      last_pop = cyc;
      pix_idx++;
    end
    if (exp_due.size() > 0 && exp_due[0] == cyc) begin
      chk("dst_en", 32'({dst_en_o, dst_we_o}), 32'd3);
      chk("dst_addr", 32'(dst_addr_o), 32'(exp_addr[0]));
      chk("dst_data", 32'(dst_data_o), 32'(exp_data[0]));
      void'(exp_due.pop_front());
      void'(exp_addr.pop_front());
      void'(exp_data.pop_front());
    end else begin
      chk("dst_idle", 32'({dst_en_o, dst_we_o}), 32'd0);
    end
    if (done_o) begin
      done_cnt++;
      chk("done_busy", 32'({busy_o, core_en_o}), 32'd0);
    end
  endtask

  task automatic fill_mem(input logic [7:0] base);
    for (int i = 0; i < 16; i++) src_mem[i] = 8'(base + i * 37);
  endtask

  task automatic start_frame();
    start_req = 1'b1;
    cycle();
    start_req = 1'b0;
    cycle();
    chk("busy_after_start", 32'({busy_o, core_en_o}), 32'd3);
    chk("err_cleared", 32'(err_o), 32'd0);
  endtask

  task automatic run_frame(input bit rnd, input bit extra, input int dmode,
                           input bit mid_start, input logic exp_err, input logic [7:0] base);
    int n;
    fill_mem(base);
    clr_model();
    rdy_rand = rnd;
    extra_res = extra;
    done_mode = dmode;
    start_frame();
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      if (mid_start && n == 5) start_req = 1'b1;
      cycle();
      start_req = 1'b0;
      n++;
    end
    chk("frame_done_seen", 32'(done_cnt), 32'd1);
    cycle();
    cycle();
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("idle_busy", 32'({busy_o, core_en_o}), 32'd0);
    chk("pix_total", 32'(pix_idx), 32'(N_PIX));
    chk("dst_left", 32'(exp_due.size()), 32'd0);
    chk("err_end", 32'(err_o), 32'(exp_err));
    if (!rnd) begin
      chk("rd_burst", 32'(last_rd - first_rd), 32'(N_PIX - 1));
      chk("pop_burst", 32'(last_pop - first_pop), 32'(N_PIX - 1));
    end
    rdy_rand = 1'b0;
    extra_res = 1'b0;
    done_mode = 0;
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    start_i = 1'b0; abort_i = 1'b0;
    src_data_i = '0; core_ready_i = 1'b0; core_valid_i = 1'b0;
    core_data_i = '0; core_done_i = 1'b0;
    start_req = 1'b0; abort_req = 1'b0;
    rdy_rand = 1'b0; extra_res = 1'b0; done_mode = 0;
    fill_mem(8'h00);
    clr_model();
    #2;
    chk("reset_state", all_outs(), 32'd0);
    cycle();
    cycle();
    rst_i = 1'b0;
    cycle();

    // Full-rate frame with a legal core_done after the last write.
    run_frame(1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h11);

    // Random stalls plus an ignored start while busy.
    run_frame(1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h5C);

    // Abort during FEED once four reads have been issued.
    fill_mem(8'h23);
    clr_model();
    start_frame();
    n = 0;
    while (rd_exp < 4 && n < 50) begin
      cycle();
      n++;
    end
    chk("abort_reads", 32'(rd_exp), 32'd4);
    abort_req = 1'b1;
    cycle();
    abort_req = 1'b0;
    flush_model();
    done_cnt = 0;
    cycle();
    chk("abort_idle", 32'({busy_o, core_en_o, core_valid_o, src_en_o}), 32'd0);
    repeat (4) cycle();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_no_err", 32'(err_o), 32'd0);
    run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h37);

    // Abort beats start in the same cycle.
    start_req = 1'b1;
    abort_req = 1'b1;
    cycle();
    start_req = 1'b0;
    abort_req = 1'b0;
    cycle();
    chk("abort_beats_start", 32'({busy_o, core_en_o}), 32'd0);

    // Asynchronous reset while draining.
    fill_mem(8'h49);
    clr_model();
    start_frame();
    n = 0;
    while (pix_idx < N_PIX && n < 100) begin
      cycle();
      n++;
    end
    cycle();
    cycle();
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    chk("pre_rst_no_done", 32'(done_cnt), 32'd0);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_async", all_outs(), 32'd0);
    flush_model();
    cycle();
    cycle();
    rst_i = 1'b0;
    cycle();
    run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h6A);

    // Ninth result, then early core_done, then a clean frame clears err_o.
    run_frame(1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h7B);
    run_frame(1'b1, 1'b0, 2, 1'b0, 1'b1, 8'h8C);
    run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h9D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
